// File: rtl/down_counter_8b_pkg.sv
// Shared control definitions for the 8-bit loadable down-counter: state encoding and
// default geometry.
package down_counter_8b_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned NIB_W_DEF = 4;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StExpired = 2'd2
    } state_e;

endpackage

// File: rtl/down_counter_4b.sv
// Loadable nibble down-counter slice. Its borrow flags a zero count with t_en high so
// that slices can be cascaded.
module down_counter_4b #(
    parameter int unsigned NIB_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_n,
    input  logic             p_en,
    input  logic             t_en,
    input  logic [NIB_W-1:0] data_in,
    output logic [NIB_W-1:0] data_out,
    output logic             borrow_out
);

    logic [NIB_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!ld_n) begin
            cnt_d = data_in;
        end else if (p_en && t_en) begin
            cnt_d = cnt_q - NIB_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign data_out   = cnt_q;
    assign borrow_out = (cnt_q == '0) && t_en;

endmodule

// File: rtl/down_counter_8b.sv
// Loadable down-counter timer built from cascaded nibble slices plus a run/expire FSM.
// Define DOWN_COUNTER_AUTORELOAD_EN for periodic operation (reload on expiry).
module down_counter_8b
    import down_counter_8b_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NIB_W = NIB_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_n,
    input  logic             p_en,
    input  logic             t_en,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             borrow_out
);

    localparam int unsigned NumNib = WIDTH / NIB_W;

    state_e             state_d, state_q;
    logic               done_d, done_q;
    logic               run, cnt, expire;
    logic               nib_ld_n;
    logic [WIDTH-1:0]   nib_ld_val;
    logic [NumNib-1:0]  nib_borrow;

    assign run    = (state_q == StRun);
    assign cnt    = p_en && t_en && run && ld_n;
    assign expire = cnt && (data_out == WIDTH'(1));

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_q <= '0;
        end else if (!ld_n) begin
            reload_q <= data_in;
        end
    end

    // Expiry reuses the slices' load path to jump back to the reload value.
    assign nib_ld_n   = ld_n && !expire;
    assign nib_ld_val = ld_n ? reload_q : data_in;
`else
    assign nib_ld_n   = ld_n;
    assign nib_ld_val = data_in;
`endif

    // Every slice is enabled by cnt; a higher slice additionally needs the borrow of the
    // slice below, so the chain's final borrow is exactly (data_out == 0) && t_en.
    for (genvar i = 0; i < NumNib; i++) begin : g_nib
        logic nib_t_en;
        if (i == 0) begin : g_lsb
            assign nib_t_en = t_en;
        end else begin : g_upper
            assign nib_t_en = nib_borrow[i-1];
        end

        down_counter_4b #(
            .NIB_W (NIB_W)
        ) u_nib (
            .clk        (clk),
            .rst        (rst),
            .ld_n       (nib_ld_n),
            .p_en       (cnt),
            .t_en       (nib_t_en),
            .data_in    (nib_ld_val[i*NIB_W +: NIB_W]),
            .data_out   (data_out[i*NIB_W +: NIB_W]),
            .borrow_out (nib_borrow[i])
        );
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        if (!ld_n) begin
            state_d = (data_in != '0) ? StRun : StIdle;
        end else if (expire) begin
            done_d  = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            state_d = StRun;
`else
            state_d = StExpired;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign busy       = run;
    assign done       = done_q;
    assign borrow_out = nib_borrow[NumNib-1];

endmodule

// File: tb/tb_down_counter_8b.sv
// Directed self-checking bench for down_counter_8b; expectations are hand-computed.
module tb_down_counter_8b;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld_n;
    logic       p_en;
    logic       t_en;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       busy;
    logic       done;
    logic       borrow_out;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clk = ~clk;

    down_counter_8b u_dut (
        .clk        (clk),
        .rst        (rst),
        .ld_n       (ld_n),
        .p_en       (p_en),
        .t_en       (t_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .busy       (busy),
        .done       (done),
        .borrow_out (borrow_out)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] exp_data,
                             input logic exp_busy, input logic exp_done);
        check({tag, ".data"}, data_out, exp_data);
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, exp_busy});
        check({tag, ".done"}, {7'd0, done}, {7'd0, exp_done});
    endtask

    initial begin
        // Reset wins over a simultaneous load.
        rst = 1'b1; ld_n = 1'b0; p_en = 1'b1; t_en = 1'b1; data_in = 8'h55;
        @(negedge clk);
        tick();
        check_all("reset", 8'h00, 1'b0, 1'b0);
        check("reset.borrow", {7'd0, borrow_out}, 8'h01);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
        rst = 1'b0; ld_n = 1'b0; data_in = 8'h04;
        tick();
        check_all("ar.load", 8'h04, 1'b1, 1'b0);
        ld_n = 1'b1;
        tick(); check_all("ar.c1", 8'h03, 1'b1, 1'b0);
        tick(); check_all("ar.c2", 8'h02, 1'b1, 1'b0);
        tick(); check_all("ar.c3", 8'h01, 1'b1, 1'b0);
        tick(); check_all("ar.c4", 8'h04, 1'b1, 1'b1);
        tick(); check_all("ar.c5", 8'h03, 1'b1, 1'b0);
        tick(); check_all("ar.c6", 8'h02, 1'b1, 1'b0);
        tick(); check_all("ar.c7", 8'h01, 1'b1, 1'b0);
        tick(); check_all("ar.c8", 8'h04, 1'b1, 1'b1);
`else
        // One-shot count of 3: done coincides with the first zero.
        rst = 1'b0; ld_n = 1'b0; data_in = 8'h03;
        tick();
        check_all("os.load", 8'h03, 1'b1, 1'b0);
        ld_n = 1'b1;
        tick(); check_all("os.c1", 8'h02, 1'b1, 1'b0);
        tick(); check_all("os.c2", 8'h01, 1'b1, 1'b0);
        tick(); check_all("os.c3", 8'h00, 1'b0, 1'b1);
        tick(); check_all("os.hold1", 8'h00, 1'b0, 1'b0);
        tick(); check_all("os.hold2", 8'h00, 1'b0, 1'b0);

        // Restart by loading during the expiry cycle.
        ld_n = 1'b0; data_in = 8'h01;
        tick(); check_all("rs.load", 8'h01, 1'b1, 1'b0);
        ld_n = 1'b1;
        tick(); check_all("rs.exp", 8'h00, 1'b0, 1'b1);
        ld_n = 1'b0; data_in = 8'h02;
        tick(); check_all("rs.reload", 8'h02, 1'b1, 1'b0);
`endif

        // Nibble borrow 0x10 -> 0x0F.
        ld_n = 1'b0; data_in = 8'h10; p_en = 1'b1; t_en = 1'b1;
        tick(); check_all("nb.load", 8'h10, 1'b1, 1'b0);
        ld_n = 1'b1;
        tick(); check_all("nb.dec", 8'h0F, 1'b1, 1'b0);
        check("nb.borrow_nz", {7'd0, borrow_out}, 8'h00);
        p_en = 1'b0;
        tick(); check_all("nb.hold", 8'h0F, 1'b1, 1'b0);

        // Load zero: idle, no done, borrow follows t_en.
        ld_n = 1'b0; data_in = 8'h00;
        tick(); check_all("z.load", 8'h00, 1'b0, 1'b0);
        ld_n = 1'b1; p_en = 1'b1;
        #1 check("z.borrow_t1", {7'd0, borrow_out}, 8'h01);
        t_en = 1'b0;
        #1 check("z.borrow_t0", {7'd0, borrow_out}, 8'h00);
        t_en = 1'b1;
        tick(); check_all("z.idle", 8'h00, 1'b0, 1'b0);

        // Enable gating on a count of 5.
        ld_n = 1'b0; data_in = 8'h05;
        tick(); check_all("eg.load", 8'h05, 1'b1, 1'b0);
        ld_n = 1'b1; p_en = 1'b0;
        tick(); check_all("eg.p0", 8'h05, 1'b1, 1'b0);
        p_en = 1'b1;
        tick(); check_all("eg.p1", 8'h04, 1'b1, 1'b0);
        p_en = 1'b0;
        tick(); check_all("eg.p0b", 8'h04, 1'b1, 1'b0);
        p_en = 1'b1;
        tick(); check_all("eg.p1b", 8'h03, 1'b1, 1'b0);
        t_en = 1'b0;
        tick(); check_all("eg.t0", 8'h03, 1'b1, 1'b0);
        t_en = 1'b1; ld_n = 1'b0; data_in = 8'h20;
        tick(); check_all("eg.midload", 8'h20, 1'b1, 1'b0);
        ld_n = 1'b1;
        tick(); check_all("eg.cross", 8'h1F, 1'b1, 1'b0);

        // Reset mid-run aborts with no done pulse.
        ld_n = 1'b0; data_in = 8'h02;
        tick(); check_all("rm.load", 8'h02, 1'b1, 1'b0);
        ld_n = 1'b1; rst = 1'b1;
        tick(); check_all("rm.rst", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check_all("rm.after", 8'h00, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
